// File: rtl/flappy_pkg.sv
// flappy_pkg: shared game states, display constants and 3-digit BCD helpers
package flappy_pkg;

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    typedef logic [11:0] bcd3_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    // Adds one in BCD with digit carries; 999 is sticky.
    function automatic bcd3_t bcd_inc(input bcd3_t v);
        if (v[3:0] != 4'd9)  return {v[11:4], v[3:0] + 4'd1};
        if (v[7:4] != 4'd9)  return {v[11:8], v[7:4] + 4'd1, 4'd0};
        if (v[11:8] != 4'd9) return {v[11:8] + 4'd1, 8'd0};
        return v;
    endfunction

endpackage

// File: rtl/seg7.sv
// seg7: one BCD digit to an active-low seven-segment pattern (gfedcba)
module seg7
    import flappy_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Non-decimal codes are shown blank.
    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_ZERO;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_keeper.sv
// score_keeper: game score / high score tracking with blinking game-over display
module score_keeper
    import flappy_pkg::*;
#(
    parameter int BLINK_CYCLES = 382
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       active,
    input  logic       gameOver,
    input  logic       extraPoint,
    input  logic       press,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic       newRecord
);

    localparam int CW = BLINK_CYCLES > 1 ? $clog2(BLINK_CYCLES) : 1;

    state_t          state;
    bcd3_t           score;
    bcd3_t           hi_score;
    bcd3_t           disp;
    logic            ep_q;
    logic            pr_q;
    logic            show_hi;
    logic [CW-1:0]   phase;
    logic            ep_rise;
    logic            pr_rise;
    logic [6:0]      seg0;
    logic [6:0]      seg1;
    logic [6:0]      seg2;

    assign ep_rise = extraPoint & ~ep_q;
    assign pr_rise = press & ~pr_q;

    // Game FSM, score/high-score registers, edge detectors and blink phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            score     <= '0;
            hi_score  <= '0;
            newRecord <= 1'b0;
            ep_q      <= 1'b0;
            pr_q      <= 1'b0;
            show_hi   <= 1'b0;
            phase     <= '0;
        end else begin
            ep_q <= extraPoint;
            pr_q <= press;
            case (state)
                IDLE: if (active && !gameOver) begin
                    state <= PLAY;
                    score <= '0;
                end
                PLAY: if (gameOver) begin
                    state     <= OVER;
                    phase     <= '0;
                    show_hi   <= 1'b0;
                    newRecord <= score > hi_score;
                    if (score > hi_score) hi_score <= score;
                end else if (ep_rise) begin
                    score <= bcd_inc(score);
                end
                OVER: if (pr_rise) begin
                    state     <= IDLE;
                    newRecord <= 1'b0;
                end else if (phase == CW'(BLINK_CYCLES - 1)) begin
                    phase   <= '0;
                    show_hi <= ~show_hi;
                end else begin
                    phase <= phase + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pick the value on the display; BCD compares correctly as plain binary.
    always_comb disp = (state == IDLE || (state == OVER && show_hi)) ? hi_score : score;

    seg7 u_seg0 (.bcd(disp[3:0]),  .seg(seg0));
    seg7 u_seg1 (.bcd(disp[7:4]),  .seg(seg1));
    seg7 u_seg2 (.bcd(disp[11:8]), .seg(seg2));

    // Leading-zero blanking on the upper two digits.
    always_comb begin
        HEX0 = seg0;
        HEX1 = (disp[11:4] == 8'd0) ? SEG_BLANK : seg1;
        HEX2 = (disp[11:8] == 4'd0) ? SEG_BLANK : seg2;
    end

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: randomized and directed checks against a behavioural score model
module tb_score_keeper;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       active = 1'b0;
    logic       gameOver = 1'b0;
    logic       extraPoint = 1'b0;
    logic       press = 1'b0;
    logic [6:0] HEX0;
    logic [6:0] HEX1;
    logic [6:0] HEX2;
    logic       newRecord;

    int vectors = 0;
    int errs = 0;

    // model: mode 0 idle, 1 playing, 2 game over
    int m_mode, m_score, m_hi, m_nr, m_blink, m_pep, m_ppr;
    logic [6:0] seg_tab [10];

    localparam logic [6:0] BL = 7'h7F;

    score_keeper #(.BLINK_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .active(active), .gameOver(gameOver),
        .extraPoint(extraPoint), .press(press),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .newRecord(newRecord)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] disp_of(input int v);
        int d2, d1, d0;
        logic [6:0] h2, h1;
        d2 = v / 100;
        d1 = (v / 10) % 10;
        d0 = v % 10;
        h2 = (d2 == 0) ? BL : seg_tab[d2];
        h1 = (d2 == 0 && d1 == 0) ? BL : seg_tab[d1];
        return {h2, h1, seg_tab[d0]};
    endfunction

    function automatic int shown();
        if (m_mode == 0) return m_hi;
        if (m_mode == 1) return m_score;
        return ((m_blink / 4) % 2) ? m_hi : m_score;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_score = 0; m_hi = 0; m_nr = 0; m_blink = 0; m_pep = 0; m_ppr = 0;
    endtask

    task automatic step();
        int epr, prr;
        epr = (extraPoint && m_pep == 0) ? 1 : 0;
        prr = (press && m_ppr == 0) ? 1 : 0;
        if (m_mode == 0) begin
            if (active && !gameOver) begin m_mode = 1; m_score = 0; end
        end else if (m_mode == 1) begin
            if (gameOver) begin
                m_mode = 2;
                m_blink = 0;
                m_nr = (m_score > m_hi) ? 1 : 0;
                if (m_nr == 1) m_hi = m_score;
            end else if (epr == 1 && m_score < 999) m_score++;
        end else begin
            if (prr == 1) begin m_mode = 0; m_nr = 0; end
            else m_blink++;
        end
        m_pep = extraPoint ? 1 : 0;
        m_ppr = press ? 1 : 0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        extraPoint = 1'b1; step();
        extraPoint = 1'b0; step();
    endtask

    task automatic start_reset();
        reset = 1'b1;
        #1;
        model_reset();
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        active = 1'b0; gameOver = 1'b0; extraPoint = 1'b0; press = 1'b0;
        start_reset();
        vectors++;
        if ({HEX2, HEX1, HEX0} !== {BL, BL, 7'h40}) begin
            errs++; $display("FAIL reset_hex: got %h want %h", {HEX2, HEX1, HEX0}, {BL, BL, 7'h40});
        end
        vectors++;
        if (newRecord !== 1'b0) begin errs++; $display("FAIL reset_nr: got %b want 0", newRecord); end
        release_reset();
        step();
        vectors++;
        if ({HEX2, HEX1, HEX0} !== disp_of(0)) begin
            errs++; $display("FAIL reset_idle: got %h want %h", {HEX2, HEX1, HEX0}, disp_of(0));
        end
    endtask

    task automatic test_hold_drop();
        start_reset(); release_reset();
        active = 1'b1; gameOver = 1'b0;
        step();
        extraPoint = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if ({HEX2, HEX1, HEX0} !== disp_of(1)) begin
                errs++; $display("FAIL hold[%0d]: got %h want %h", i, {HEX2, HEX1, HEX0}, disp_of(1));
            end
        end
        extraPoint = 1'b0; step();
        extraPoint = 1'b1; gameOver = 1'b1; step();
        vectors++;
        if ({HEX2, HEX1, HEX0} !== disp_of(1)) begin
            errs++; $display("FAIL drop_score: got %h want %h", {HEX2, HEX1, HEX0}, disp_of(1));
        end
        vectors++;
        if (newRecord !== 1'b1) begin errs++; $display("FAIL drop_over_nr: got %b want 1", newRecord); end
        extraPoint = 1'b0; gameOver = 1'b0; active = 1'b0; press = 1'b1; step();
        vectors++;
        if (newRecord !== 1'b0) begin errs++; $display("FAIL drop_idle_nr: got %b want 0", newRecord); end
        press = 1'b0; step();
    endtask

    task automatic test_carry();
        start_reset(); release_reset();
        active = 1'b1; gameOver = 1'b0; step();
        for (int i = 1; i <= 109; i++) begin
            pulse();
            vectors++;
            if ({HEX2, HEX1, HEX0} !== disp_of(i)) begin
                errs++; $display("FAIL carry[%0d]: got %h want %h", i, {HEX2, HEX1, HEX0}, disp_of(i));
            end
        end
        vectors++;
        if ({HEX2, HEX1, HEX0} !== {7'h79, 7'h40, 7'h10}) begin
            errs++; $display("FAIL carry_109: got %h want %h", {HEX2, HEX1, HEX0}, {7'h79, 7'h40, 7'h10});
        end
        pulse();
        vectors++;
        if ({HEX2, HEX1, HEX0} !== {7'h79, 7'h79, 7'h40}) begin
            errs++; $display("FAIL carry_110: got %h want %h", {HEX2, HEX1, HEX0}, {7'h79, 7'h79, 7'h40});
        end
    endtask

    task automatic test_saturation();
        start_reset(); release_reset();
        active = 1'b1; gameOver = 1'b0; step();
        repeat (1005) pulse();
        vectors++;
        if ({HEX2, HEX1, HEX0} !== {7'h10, 7'h10, 7'h10} || m_score != 999) begin
            errs++; $display("FAIL sat_999: got %h want %h", {HEX2, HEX1, HEX0}, {7'h10, 7'h10, 7'h10});
        end
        pulse();
        vectors++;
        if ({HEX2, HEX1, HEX0} !== disp_of(999)) begin
            errs++; $display("FAIL sat_hold: got %h want %h", {HEX2, HEX1, HEX0}, disp_of(999));
        end
    endtask

    task automatic test_high_score();
        start_reset(); release_reset();
        active = 1'b1; gameOver = 1'b0; step();
        repeat (12) pulse();
        gameOver = 1'b1; step();
        vectors++;
        if (newRecord !== 1'b1) begin errs++; $display("FAIL hs_nr1: got %b want 1", newRecord); end
        vectors++;
        if ({HEX2, HEX1, HEX0} !== disp_of(12)) begin
            errs++; $display("FAIL hs_over1: got %h want %h", {HEX2, HEX1, HEX0}, disp_of(12));
        end
        active = 1'b0; gameOver = 1'b0; press = 1'b1; step();
        vectors++;
        if ({HEX2, HEX1, HEX0} !== {BL, 7'h79, 7'h24} || newRecord !== 1'b0) begin
            errs++; $display("FAIL hs_idle: got %h nr %b want %h nr 0", {HEX2, HEX1, HEX0}, newRecord, {BL, 7'h79, 7'h24});
        end
        press = 1'b0; step();
        active = 1'b1; step();
        repeat (7) pulse();
        gameOver = 1'b1; step();
        vectors++;
        if (newRecord !== 1'b0) begin errs++; $display("FAIL hs_nr2: got %b want 0", newRecord); end
        repeat (4) step();
        vectors++;
        if ({HEX2, HEX1, HEX0} !== disp_of(12)) begin
            errs++; $display("FAIL hs_keep: got %h want %h", {HEX2, HEX1, HEX0}, disp_of(12));
        end
        active = 1'b0; gameOver = 1'b0; press = 1'b1; step();
        press = 1'b0; step();
    endtask

    task automatic test_blink();
        int want;
        active = 1'b1; gameOver = 1'b0; step();
        repeat (3) pulse();
        gameOver = 1'b1; step();
        for (int k = 0; k < 12; k++) begin
            want = ((k / 4) % 2) ? 12 : 3;
            vectors++;
            if ({HEX2, HEX1, HEX0} !== disp_of(want) || shown() != want) begin
                errs++; $display("FAIL blink[%0d]: got %h want %h", k, {HEX2, HEX1, HEX0}, disp_of(want));
            end
            step();
        end
        start_reset();
        vectors++;
        if ({HEX2, HEX1, HEX0} !== {BL, BL, 7'h40} || newRecord !== 1'b0) begin
            errs++; $display("FAIL blink_reset: got %h nr %b want %h nr 0", {HEX2, HEX1, HEX0}, newRecord, {BL, BL, 7'h40});
        end
        active = 1'b0; gameOver = 1'b0;
        release_reset();
        step();
        vectors++;
        if ({HEX2, HEX1, HEX0} !== disp_of(0)) begin
            errs++; $display("FAIL blink_hi_cleared: got %h want %h", {HEX2, HEX1, HEX0}, disp_of(0));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                start_reset();
                release_reset();
            end
            active = $urandom_range(0, 3) != 0;
            gameOver = $urandom_range(0, 24) == 0;
            extraPoint = $urandom_range(0, 1) == 1;
            press = $urandom_range(0, 5) == 0;
            step();
            vectors++;
            if ({HEX2, HEX1, HEX0} !== disp_of(shown()) || newRecord !== m_nr[0]) begin
                errs++;
                $display("FAIL random[%0d]: got %h nr %b want %h nr %0d", i, {HEX2, HEX1, HEX0}, newRecord, disp_of(shown()), m_nr);
            end
        end
    endtask

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        model_reset();
        test_reset();
        test_hold_drop();
        test_carry();
        test_saturation();
        test_high_score();
        test_blink();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter BLINK_CYCLES, default 382, is the number of clk cycles per OVER-state display phase (about 0.5 s at a 2^16-divided clock).
REQ-002 Port clk, input, 1 bit: the single clock, the same divided clock that drives the game stages.
REQ-003 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port active, input, 1 bit: game-started level from the activation stage.
REQ-005 Port gameOver, input, 1 bit: collision level from the crash stage.
REQ-006 Port extraPoint, input, 1 bit: pipe-cleared indication from the crash stage; it may be held for more than one cycle.
REQ-007 Port press, input, 1 bit: synchronized key press, a level.
REQ-008 Ports HEX0, HEX1, HEX2, output, 7 bits each: active-low seven-segment digits, ones, tens and hundreds.
REQ-009 Port newRecord, output, 1 bit: the last game set a new high score.

Function
REQ-010 The block SHALL hold two 3-digit BCD registers, score and hiScore, each ranging 000 to 999.
REQ-011 The block SHALL register extraPoint and press and act only on their rising edges (current 1, previous 0).
REQ-012 The FSM SHALL have three states: IDLE, PLAY and OVER.
REQ-013 IDLE -> PLAY SHALL occur when active=1 and gameOver=0; on that edge score clears to 000.
REQ-014 PLAY -> OVER SHALL occur when gameOver=1.
REQ-015 OVER -> IDLE SHALL occur on a press rising edge; score is retained until the next entry to PLAY.
REQ-016 In PLAY, an extraPoint rising edge with gameOver=0 SHALL increment score by 1 in BCD, carrying 9->0 into the next digit, effective on the same clk edge.
REQ-017 If gameOver=1 in the same cycle as an extraPoint rising edge, gameOver SHALL have priority and the point SHALL be dropped.
REQ-018 score SHALL saturate at 999; further increments are ignored.
REQ-019 On the PLAY->OVER edge: if score > hiScore, hiScore <= score and newRecord <= 1; otherwise newRecord <= 0.
REQ-020 newRecord SHALL clear on the OVER->IDLE edge.
REQ-021 Display in IDLE SHALL show hiScore.
REQ-022 Display in PLAY SHALL show score.
REQ-023 Display in OVER SHALL alternate score and hiScore every BLINK_CYCLES cycles, starting with score on OVER entry.
REQ-024 The phase counter SHALL be cleared on OVER entry and wrap at BLINK_CYCLES-1.
REQ-025 Leading-zero blanking SHALL apply: HEX2 is blank (7'b1111111) when the hundreds digit is 0, and HEX1 is blank when both hundreds and tens are 0. HEX0 is always driven, so 0 shows as 7'b1000000.
REQ-026 HEX outputs SHALL be combinational decodes of registered state, so an update is visible immediately after the updating edge with no extra latency.
REQ-027 An extraPoint held high for N cycles SHALL count exactly once.

Reset
REQ-028 Reset SHALL asynchronously set state=IDLE, score=000, hiScore=000, newRecord=0, edge-detect registers=0 and phase counter=0.
REQ-029 During reset, HEX2=HEX1=7'b1111111, HEX0=7'b1000000 and newRecord=0.
REQ-030 Reset asserted mid-game SHALL discard the game with no hiScore update.

Structure
REQ-031 Shared package flappy_pkg SHALL contain the state enum (IDLE, PLAY, OVER), the SEG_BLANK and SEG_ZERO constants, and a 12-bit bcd3_t typedef.
REQ-032 Sub-module seg7 (4-bit BCD to 7-bit active-low) SHALL be instantiated three times.
REQ-033 BCD increment with saturation SHALL be a function in flappy_pkg.

Verification
REQ-034 Scenario, reset only: pulse reset -> HEX2/HEX1 blank, HEX0=7'b1000000, newRecord=0.
REQ-035 Scenario, hold and drop: active=1, then extraPoint held 5 cycles -> score=001; then extraPoint and gameOver rise on the same cycle -> score stays 001 and state=OVER.
REQ-036 Scenario, carry and blanking: 109 extraPoint pulses -> HEX2=1, HEX1=0 (digit shown, not blank), HEX0=9; one more pulse -> 110.
REQ-037 Scenario, saturation: 1005 pulses -> score=999; one more pulse -> 999.
REQ-038 Scenario, high score: game 1 scores 12 then gameOver -> hiScore=012, newRecord=1. press -> IDLE shows 12 and newRecord=0. Game 2 scores 7 then gameOver -> hiScore stays 012, newRecord=0.
REQ-039 Scenario, blink and mid-OVER reset: in OVER with BLINK_CYCLES=4, display alternates score for 4 cycles then hiScore for 4 cycles; asserting reset mid-OVER gives IDLE, hiScore=000 and blanked digits immediately.
